// File: rtl/pulse_train_monitor.sv
// Measures pulse count, period and high time of each burst on an asynchronous
// PWM line, and strobes burst_done once the line has stayed quiet long enough.
module pulse_train_monitor #(
  parameter int CNT_W        = 26,
  parameter int PCNT_W       = 16,
  parameter int IDLE_TIMEOUT = 100000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              pwm_in,
  input  logic              clr,
  output logic              busy,
  output logic [PCNT_W-1:0] pulse_cnt,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic              burst_done
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [CNT_W-1:0] IDLE_LIM  = CNT_W'(IDLE_TIMEOUT);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [PCNT_W-1:0] sat_inc_pcnt(input logic [PCNT_W-1:0] v);
    return (v == '1) ? v : v + PCNT_W'(1);
  endfunction

  state_t              state_q, state_d;
  logic [2:0]          sync_q, sync_d;
  logic [CNT_W-1:0]    edge_tmr_q, edge_tmr_d;
  logic [CNT_W-1:0]    idle_tmr_q, idle_tmr_d;
  logic [PCNT_W-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic [CNT_W-1:0]    high_time_q, high_time_d;
  logic                burst_done_q, burst_done_d;
  logic                rise, fall;

  // sync_q[0..1] is the two-flop synchronizer, sync_q[2] the edge-detect delay
  always_comb begin
    sync_d = {sync_q[1:0], pwm_in};
    rise   = sync_q[1] & ~sync_q[2];
    fall   = ~sync_q[1] & sync_q[2];
  end

  always_comb begin
    state_d      = state_q;
    pulse_cnt_d  = pulse_cnt_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    burst_done_d = 1'b0;
    edge_tmr_d   = rise ? CNT_W'(1) : sat_inc_cnt(edge_tmr_q);
    if (rise || fall)
      idle_tmr_d = '0;
    else if (idle_tmr_q >= IDLE_LIM)
      idle_tmr_d = IDLE_LIM;
    else
      idle_tmr_d = idle_tmr_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d     = ACTIVE;
          pulse_cnt_d = PCNT_W'(1);
          period_d    = '0;
          high_time_d = '0;
        end
      end
      ACTIVE: begin
        if (rise) begin
          period_d    = edge_tmr_q;
          pulse_cnt_d = sat_inc_pcnt(pulse_cnt_q);
        end else if (fall) begin
          high_time_d = edge_tmr_q;
        end else if (idle_tmr_q == IDLE_LAST) begin
          burst_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // clr wipes everything except the synchronizer, so a coincident rise is lost
    if (clr) begin
      state_d      = IDLE;
      pulse_cnt_d  = '0;
      period_d     = '0;
      high_time_d  = '0;
      burst_done_d = 1'b0;
      edge_tmr_d   = '0;
      idle_tmr_d   = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      edge_tmr_q   <= '0;
      idle_tmr_q   <= '0;
      pulse_cnt_q  <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      edge_tmr_q   <= edge_tmr_d;
      idle_tmr_q   <= idle_tmr_d;
      pulse_cnt_q  <= pulse_cnt_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      burst_done_q <= burst_done_d;
    end
  end

  assign busy       = (state_q == ACTIVE);
  assign pulse_cnt  = pulse_cnt_q;
  assign period     = period_q;
  assign high_time  = high_time_q;
  assign burst_done = burst_done_q;

endmodule

// File: tb/tb_pulse_train_monitor.sv
// Directed bench for pulse_train_monitor with shrunken widths and timeout so
// saturation and timeout cases fit in a short run.
module tb_pulse_train_monitor;

  localparam int CNT_W        = 10;
  localparam int PCNT_W       = 4;
  localparam int IDLE_TIMEOUT = 1000;

  logic              clk = 1'b0;
  logic              sys_rst, pwm_in, clr;
  logic              busy, burst_done;
  logic [PCNT_W-1:0] pulse_cnt;
  logic [CNT_W-1:0]  period, high_time;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  pulse_train_monitor #(
    .CNT_W(CNT_W), .PCNT_W(PCNT_W), .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .pwm_in(pwm_in), .clr(clr),
    .busy(busy), .pulse_cnt(pulse_cnt), .period(period),
    .high_time(high_time), .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (burst_done === 1'b1) done_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      tick(hi);
      pwm_in = 1'b0;
      tick(lo);
    end
  endtask

  task automatic wait_idle(input string tag);
    int d0;
    int k;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < 1500) begin
      tick(1);
      k++;
    end
    chk(tag, done_cnt - d0, 1);
    tick(1);
  endtask

  initial begin
    int d0;
    sys_rst = 1'b1; clr = 1'b0; pwm_in = 1'b0;
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_pcnt", pulse_cnt, 0);
    chk("rst_period", period, 0);
    chk("rst_high", high_time, 0);
    chk("rst_done", burst_done, 0);
    sys_rst = 1'b0;
    tick(1);

    // Burst of 5 pulses, 100 high / 100 low, with exact latency and timeout
    pwm_in = 1'b1;
    tick(2);
    chk("t1_busy_early", busy, 0);
    tick(1);
    chk("t1_busy_3cyc", busy, 1);
    chk("t1_first_pcnt", pulse_cnt, 1);
    chk("t1_first_period", period, 0);
    tick(97);
    pwm_in = 1'b0;
    tick(100);
    pulses(4, 100, 100);
    chk("t1_pcnt", pulse_cnt, 5);
    chk("t1_period", period, 200);
    chk("t1_high", high_time, 100);
    tick(902);
    chk("t1_done_early", burst_done, 0);
    chk("t1_busy_pre", busy, 1);
    tick(1);
    chk("t1_done", burst_done, 1);
    chk("t1_busy_post", busy, 0);
    tick(1);
    chk("t1_done_one", burst_done, 0);
    chk("t1_pcnt_held", pulse_cnt, 5);

    // Two consecutive bursts; results held between them
    pulses(3, 100, 100);
    wait_idle("t2_done_a");
    chk("t2_pcnt_held", pulse_cnt, 3);
    chk("t2_busy_idle", busy, 0);
    pulses(2, 40, 60);
    chk("t2_pcnt", pulse_cnt, 2);
    chk("t2_period", period, 100);
    chk("t2_high", high_time, 40);
    wait_idle("t2_done_b");

    // clr after the 4th rise of a 10-pulse burst
    pulses(3, 100, 100);
    pwm_in = 1'b1;
    tick(3);
    chk("t3_pcnt4", pulse_cnt, 4);
    d0 = done_cnt;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("t3_clr_busy", busy, 0);
    chk("t3_clr_pcnt", pulse_cnt, 0);
    chk("t3_clr_period", period, 0);
    chk("t3_clr_high", high_time, 0);
    tick(96);
    pwm_in = 1'b0;
    tick(100);
    pulses(6, 100, 100);
    chk("t3_no_done", done_cnt - d0, 0);
    chk("t3_pcnt", pulse_cnt, 6);
    chk("t3_period", period, 200);
    wait_idle("t3_done");

    // Single long pulse
    pulses(1, 251, 0);
    wait_idle("t4_done");
    chk("t4_pcnt", pulse_cnt, 1);
    chk("t4_period", period, 0);
    chk("t4_high", high_time, 251);

    // Pulse counter saturation: 17 rises into a 4-bit counter
    pulses(17, 4, 4);
    chk("t5_pcnt_sat", pulse_cnt, 15);
    chk("t5_period", period, 8);
    chk("t5_high", high_time, 4);
    wait_idle("t5_done");

    // Period timer saturation: 1200-cycle period into a 10-bit timer
    pulses(2, 600, 600);
    chk("t5b_period_sat", period, 1023);
    chk("t5b_high", high_time, 600);
    chk("t5b_pcnt", pulse_cnt, 2);
    wait_idle("t5b_done");

    // sys_rst mid-burst, then continue
    pulses(3, 100, 100);
    d0 = done_cnt;
    sys_rst = 1'b1;
    tick(1);
    sys_rst = 1'b0;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_pcnt", pulse_cnt, 0);
    chk("t6_rst_period", period, 0);
    pulses(2, 100, 100);
    chk("t6_pcnt", pulse_cnt, 2);
    chk("t6_period", period, 200);
    sys_rst = 1'b1; clr = 1'b1;
    tick(1);
    sys_rst = 1'b0; clr = 1'b0;
    chk("t6_rstclr_busy", busy, 0);
    chk("t6_rstclr_pcnt", pulse_cnt, 0);
    tick(1100);
    chk("t6_no_done", done_cnt - d0, 0);

    // clr coinciding with a detected rise discards that edge
    pwm_in = 1'b1;
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("t7_clr_rise_busy", busy, 0);
    chk("t7_clr_rise_pcnt", pulse_cnt, 0);
    tick(50);
    pwm_in = 1'b0;
    tick(50);
    pulses(1, 30, 30);
    chk("t7_fresh_pcnt", pulse_cnt, 1);
    chk("t7_fresh_high", high_time, 30);
    wait_idle("t7_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
